mul_div_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file and consumes its two read ports (DR1 → a, DR2 → b) for MULT/MULTU/DIV/DIVU.
- Results are held in HI/LO. Those registers are read back through hi/lo for MFHI/MFLO, whose value reaches the register-file write-data input via the write-back mux.
- Multi-cycle, with a start/busy/done handshake to the control unit.

---
 rtl/mul_div_unit.sv | 141 ++++++++++++++
 tb/tb_mul_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. One operation takes WIDTH+1 cycles after the start edge: WIDTH
// shift-add / restoring shift-subtract iterations on magnitudes, then one
// sign-fixup cycle that writes HI/LO and raises done for a cycle.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   start, op       op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled in IDLE)
//   a, b            operands (dividend / divisor for divides)
//   hi_we, lo_we    MTHI / MTLO enables, data on wdata (IDLE and !start only)
//   hi, lo          HI / LO registers
//   busy            operation in progress
//   done            one-cycle pulse after HI/LO are written by an operation
//   div_zero        last operation was a divide by zero (held until next start)
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic               sa_q, sb_q, bz_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   dvs_q;   // |b|: multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q;   // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     madd, rsh, rdiff;
  logic [2*WIDTH-1:0] acc_nxt, prod;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign busy = (state != IDLE);

  // Sign bits are only meaningful for signed ops; unsigned ops take raw values.
  always_comb begin
    abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
    abs_b = (op[0] && b[WIDTH-1]) ? -b : b;
  end

  // One iteration of either algorithm.
  always_comb begin
    madd  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};
    // Remainder shifted left with the next dividend bit; WIDTH+1 bits so the
    // compare against a full-width divisor cannot overflow.
    rsh   = acc_q[2*WIDTH-1:WIDTH-1];
    rdiff = rsh - {1'b0, dvs_q};
    if (!op_q[1])
      acc_nxt = acc_q[0] ? {madd, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    else if (!rdiff[WIDTH])
      acc_nxt = {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Sign fixup (sa_q/sb_q are zero for unsigned ops).
  always_comb begin
    prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_s = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      a_q      <= '0;
      dvs_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            a_q      <= a;
            dvs_q    <= abs_b;
            sa_q     <= op[0] & a[WIDTH-1];
            sb_q     <= op[0] & b[WIDTH-1];
            bz_q     <= (b == '0);
            acc_q    <= {{WIDTH{1'b0}}, abs_a};
            cnt_q    <= '0;
            div_zero <= 1'b0;
            state    <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          state <= IDLE;
          done  <= 1'b1;
          if (!op_q[1]) begin
            {hi, lo} <= prod;
          end else if (bz_q) begin
            // Divide by zero: dividend passes through to HI, LO saturates.
            hi       <= a_q;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi <= rem_s;
            lo <= quo_s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0, wdata = '0;
  logic          hi_we = 1'b0, lo_we = 1'b0;
  logic [W-1:0]  hi, lo;
  logic          busy, done, div_zero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] hi, lo, hi_m1, pre_hi, pre_lo;
    logic         dz, dz_m1, busy1;
    int           done_at, ndone;
  } obs_t;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the architectural rules. Returns {dz, hi, lo}.
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'd0) begin
      p = {32'b0, x} * {32'b0, y};
      return {1'b0, p};
    end else if (o == 2'd1) begin
      p = 64'(sx * sy);
      return {1'b0, p};
    end else if (y == 0) begin
      return {1'b1, x, 32'hFFFF_FFFF};
    end else if (o == 2'd2) begin
      return {1'b0, x % y, x / y};
    end else begin
      p[63:32] = 32'(sx % sy);
      p[31:0]  = 32'(sx / sy);
      return {1'b0, p};
    end
  endfunction

  // Drives one operation and records what the DUT shows; callers compare.
  // Negedge index j: j-th negedge after the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit disturb, input bit we_start, output obs_t r);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    if (we_start) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
    r.done_at = 0; r.ndone = 0;
    r.pre_hi = '0; r.pre_lo = '0; r.hi = '0; r.lo = '0; r.dz = 1'b0;
    for (int j = 1; j <= W + 3; j++) begin
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      if (j == 1) begin
        a = $urandom; b = $urandom; op = 2'($urandom);
        r.busy1 = busy; r.hi_m1 = hi; r.dz_m1 = div_zero;
      end
      if (disturb && j == 5) begin
        start = 1'b1; lo_we = 1'b1; wdata = 32'd189;
      end
      if (j == W + 1) begin r.pre_hi = hi; r.pre_lo = lo; end
      if (done) begin
        r.ndone++;
        if (r.done_at == 0) r.done_at = j;
      end
      if (j == W + 2) begin r.hi = hi; r.lo = lo; r.dz = div_zero; end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (hi !== '0)       begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0)       begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  to [8];
    logic [31:0] ta [8], tb [8], thi [8], tlo [8];
    logic        tdz [8];
    obs_t r;
    to  = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    ta  = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9, 32'd7, 32'd236, 32'd2};
    tb  = '{32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd3};
    thi = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'hFFFF_FFFF, 32'd1, 32'd236, 32'd0};
    tlo = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h8000_0000, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd6};
    tdz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_op(to[i], ta[i], tb[i], 1'b0, 1'b0, r);
      checks++; if (r.hi !== thi[i]) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, r.hi, thi[i]); end
      checks++; if (r.lo !== tlo[i]) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, r.lo, tlo[i]); end
      checks++; if (r.dz !== tdz[i]) begin failures++; $display("FAIL dir%0d_dz got=%b exp=%b", i, r.dz, tdz[i]); end
      checks++; if (r.dz_m1 !== 1'b0) begin failures++; $display("FAIL dir%0d_dz_clear got=%b exp=0", i, r.dz_m1); end
      checks++; if (r.busy1 !== 1'b1) begin failures++; $display("FAIL dir%0d_busy got=%b exp=1", i, r.busy1); end
      checks++; if (r.done_at !== W + 2) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, r.done_at, W + 2); end
      checks++; if (r.ndone !== 1) begin failures++; $display("FAIL dir%0d_ndone got=%0d exp=1", i, r.ndone); end
    end
  endtask

  task automatic test_mtx();
    obs_t r;
    @(negedge clk); hi_we = 1'b1; wdata = 32'd310;
    @(negedge clk); hi_we = 1'b0;
    checks++; if (hi !== 32'd310) begin failures++; $display("FAIL mthi got=%h exp=%h", hi, 32'd310); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    checks++; if ({hi, lo} !== {2{32'h1234_5678}}) begin failures++; $display("FAIL mthi_mtlo got=%h_%h exp=12345678_12345678", hi, lo); end
    // start and lo_we pulsed mid-CALC must be ignored
    run_op(2'd0, 32'd5, 32'd5, 1'b1, 1'b0, r);
    checks++; if (r.pre_lo !== 32'h1234_5678) begin failures++; $display("FAIL busy_lo_we got=%h exp=12345678", r.pre_lo); end
    checks++; if (r.lo !== 32'd25) begin failures++; $display("FAIL busy_lo got=%h exp=%h", r.lo, 32'd25); end
    checks++; if (r.hi !== 32'd0) begin failures++; $display("FAIL busy_hi got=%h exp=0", r.hi); end
    checks++; if (r.ndone !== 1) begin failures++; $display("FAIL busy_ndone got=%0d exp=1", r.ndone); end
    // hi_we together with start: start wins
    run_op(2'd0, 32'd2, 32'd3, 1'b0, 1'b1, r);
    checks++; if (r.hi_m1 !== 32'd0) begin failures++; $display("FAIL we_start_hi got=%h exp=0", r.hi_m1); end
    checks++; if (r.lo !== 32'd6) begin failures++; $display("FAIL we_start_lo got=%h exp=6", r.lo); end
  endtask

  task automatic test_reset_midop();
    obs_t r;
    int nd;
    @(negedge clk); start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=0", hi, lo); end
    checks++; if ({busy, done, div_zero} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags got=%b exp=000", {busy, done, div_zero}); end
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (45) begin @(negedge clk); if (done) nd++; end
    checks++; if (nd !== 0) begin failures++; $display("FAIL rst_mid_nodone got=%0d exp=0", nd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    run_op(2'd2, 32'd1000, 32'd3, 1'b0, 1'b0, r);
    checks++; if ({r.hi, r.lo} !== {32'd1, 32'd333}) begin failures++; $display("FAIL rst_mid_redo got=%h_%h exp=1_333", r.hi, r.lo); end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [64:0] e;
    @(negedge clk); start = 1'b1; op = 2'd1; a = 32'hFFFF_FF00; b = 32'd77;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!done && k < 60) begin @(negedge clk); k++; end
    checks++; if (!done) begin failures++; $display("FAIL b2b_first_done got=0 exp=1 (timeout)"); end
    e = ref_op(2'd1, 32'hFFFF_FF00, 32'd77);
    checks++; if ({hi, lo} !== e[63:0]) begin failures++; $display("FAIL b2b_first got=%h_%h exp=%h", hi, lo, e[63:0]); end
    // start in the same cycle done is high
    start = 1'b1; op = 2'd3; a = 32'hFFFF_FC18; b = 32'd7;
    k = 0;
    do begin @(negedge clk); start = 1'b0; k++; end while (!done && k < 60);
    checks++; if (k !== W + 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", k, W + 2); end
    e = ref_op(2'd3, 32'hFFFF_FC18, 32'd7);
    checks++; if ({hi, lo} !== e[63:0]) begin failures++; $display("FAIL b2b_second got=%h_%h exp=%h", hi, lo, e[63:0]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    obs_t r;
    logic [1:0]  o;
    logic [31:0] x, y, ph, pl;
    logic [64:0] e;
    ph = hi; pl = lo;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        3: x = 32'h8000_0000;
        default: ;
      endcase
      e = ref_op(o, x, y);
      run_op(o, x, y, 1'b0, 1'b0, r);
      checks++; if ({r.pre_hi, r.pre_lo} !== {ph, pl}) begin failures++; $display("FAIL rnd%0d_hold got=%h_%h exp=%h_%h", i, r.pre_hi, r.pre_lo, ph, pl); end
      checks++; if ({r.hi, r.lo} !== e[63:0]) begin failures++; $display("FAIL rnd%0d_res op=%0d a=%h b=%h got=%h_%h exp=%h", i, o, x, y, r.hi, r.lo, e[63:0]); end
      checks++; if (r.dz !== e[64]) begin failures++; $display("FAIL rnd%0d_dz got=%b exp=%b", i, r.dz, e[64]); end
      checks++; if (r.done_at !== W + 2) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, r.done_at, W + 2); end
      ph = e[63:32]; pl = e[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mtx();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
